l2_bus_adapter: RTL and testbench

- Sits directly downstream of the L2 shared cache. Consumes its line-wide memory request/response channel and drives the 32-bit OBI system bus.
- Splits each cache-line request into sequential 32-bit word transactions, with one outstanding bus transaction at a time.
- For reads, collects the returned words into a line and sends them back upstream with the original tag.

---
 rtl/l2_bus_adapter.sv | 159 +++++++++++++++
 tb/tb_l2_bus_adapter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_bus_adapter.sv
// Line-to-word bridge between the L2 memory channel and a 32-bit OBI bus, one outstanding word at a time.
// Optional macro L2_BUS_ADAPTER_SKIP_ZERO_BE_EN: write words with all-zero byte enables are not issued.
module l2_bus_adapter #(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = 28,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mem_req_valid_i,
  input  logic                     mem_req_rw_i,
  input  logic [LINE_SIZE-1:0]     mem_req_byteen_i,
  input  logic [ADDR_WIDTH-1:0]    mem_req_addr_i,
  input  logic [LINE_SIZE*8-1:0]   mem_req_data_i,
  input  logic [TAG_WIDTH-1:0]     mem_req_tag_i,
  output logic                     mem_req_ready_o,
  output logic                     mem_rsp_valid_o,
  output logic [LINE_SIZE*8-1:0]   mem_rsp_data_o,
  output logic [TAG_WIDTH-1:0]     mem_rsp_tag_o,
  input  logic                     mem_rsp_ready_i,
  output logic                     bus_req_o,
  input  logic                     bus_gnt_i,
  output logic [31:0]              bus_addr_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_be_o,
  output logic [31:0]              bus_wdata_o,
  input  logic                     bus_rvalid_i,
  input  logic [31:0]              bus_rdata_i
);

  localparam int NW = LINE_SIZE / 4;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LB = $clog2(LINE_SIZE);
  localparam int BW = ADDR_WIDTH + LB;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     load, capture;
  logic                     rw_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [LINE_SIZE-1:0]     byteen_q;
  logic [LINE_SIZE*8-1:0]   data_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [LINE_SIZE*8-1:0]   line_q;
  logic                     in_req;

  // Byte address of word i of the line, fitted to the 32-bit bus.
  function automatic logic [31:0] word_addr(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [IW-1:0] i);
    logic [BW-1:0] b;
    b = {a, {LB{1'b0}}} | (BW'(i) << 2);
    return 32'(b);
  endfunction

`ifdef L2_BUS_ADAPTER_SKIP_ZERO_BE_EN
  logic [IW:0] nxt;

  // Lowest word at or above start with any byte enabled; MSB flags whether one exists.
  function automatic logic [IW:0] next_word(input logic [LINE_SIZE-1:0] be, input int start);
    logic [IW:0] r;
    r = '0;
    for (int j = NW - 1; j >= 0; j--) begin
      if (j >= start && be[4*j +: 4] != 4'h0) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    capture = 1'b0;
`ifdef L2_BUS_ADAPTER_SKIP_ZERO_BE_EN
    nxt     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req_valid_i) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = REQ;
`ifdef L2_BUS_ADAPTER_SKIP_ZERO_BE_EN
          if (mem_req_rw_i) begin
            nxt = next_word(mem_req_byteen_i, 0);
            if (nxt[IW]) idx_d = nxt[IW-1:0];
            else         state_d = IDLE;
          end
`endif
        end
      end
      REQ: begin
        if (bus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          capture = !rw_q;
          if (idx_q == IW'(NW - 1)) begin
            state_d = rw_q ? IDLE : RSP;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = REQ;
          end
`ifdef L2_BUS_ADAPTER_SKIP_ZERO_BE_EN
          if (rw_q) begin
            nxt = next_word(byteen_q, int'(idx_q) + 1);
            if (nxt[IW]) begin
              idx_d   = nxt[IW-1:0];
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end
`endif
        end
      end
      RSP: begin
        if (mem_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Request and line storage carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk_i) begin
    if (load) begin
      rw_q     <= mem_req_rw_i;
      addr_q   <= mem_req_addr_i;
      byteen_q <= mem_req_byteen_i;
      data_q   <= mem_req_data_i;
      tag_q    <= mem_req_tag_i;
    end
    if (capture) line_q[32*idx_q +: 32] <= bus_rdata_i;
  end

  assign in_req          = (state_q == REQ);
  assign mem_req_ready_o = (state_q == IDLE);
  assign bus_req_o       = in_req;
  assign bus_addr_o      = in_req ? word_addr(addr_q, idx_q) : 32'h0;
  assign bus_we_o        = in_req & rw_q;
  assign bus_be_o        = in_req ? (rw_q ? byteen_q[4*idx_q +: 4] : 4'hF) : 4'h0;
  assign bus_wdata_o     = in_req ? data_q[32*idx_q +: 32] : 32'h0;
  assign mem_rsp_valid_o = (state_q == RSP);
  assign mem_rsp_data_o  = (state_q == RSP) ? line_q : '0;
  assign mem_rsp_tag_o   = (state_q == RSP) ? tag_q : '0;

endmodule

// File: tb/tb_l2_bus_adapter.sv
// Self-checking bench for l2_bus_adapter: directed scenarios plus randomized lines against a transaction-level model.
module tb_l2_bus_adapter;

  localparam int LINE_SIZE = 16;
  localparam int AW        = 28;
  localparam int TW        = 8;
  localparam int NW        = LINE_SIZE / 4;
  localparam int DW        = LINE_SIZE * 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 mem_req_valid_i;
  logic                 mem_req_rw_i;
  logic [LINE_SIZE-1:0] mem_req_byteen_i;
  logic [AW-1:0]        mem_req_addr_i;
  logic [DW-1:0]        mem_req_data_i;
  logic [TW-1:0]        mem_req_tag_i;
  logic                 mem_req_ready_o;
  logic                 mem_rsp_valid_o;
  logic [DW-1:0]        mem_rsp_data_o;
  logic [TW-1:0]        mem_rsp_tag_o;
  logic                 mem_rsp_ready_i;
  logic                 bus_req_o;
  logic                 bus_gnt_i;
  logic [31:0]          bus_addr_o;
  logic                 bus_we_o;
  logic [3:0]           bus_be_o;
  logic [31:0]          bus_wdata_o;
  logic                 bus_rvalid_i;
  logic [31:0]          bus_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_w [NW];

  l2_bus_adapter #(.LINE_SIZE(LINE_SIZE), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_valid_i(mem_req_valid_i), .mem_req_rw_i(mem_req_rw_i),
    .mem_req_byteen_i(mem_req_byteen_i), .mem_req_addr_i(mem_req_addr_i),
    .mem_req_data_i(mem_req_data_i), .mem_req_tag_i(mem_req_tag_i),
    .mem_req_ready_o(mem_req_ready_o), .mem_rsp_valid_o(mem_rsp_valid_o),
    .mem_rsp_data_o(mem_rsp_data_o), .mem_rsp_tag_o(mem_rsp_tag_o),
    .mem_rsp_ready_i(mem_rsp_ready_i), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues one line and plays the OBI slave; abort_word >= 0 resets the DUT in WAIT of that word.
  task automatic run_line(input logic rw, input logic [AW-1:0] addr, input logic [LINE_SIZE-1:0] be,
                          input logic [DW-1:0] data, input logic [TW-1:0] tag,
                          input int gnt_dly, input int rsp_dly, input int abort_word);
    logic [31:0] e_addr [$];
    logic [3:0]  e_be   [$];
    logic [31:0] e_wd   [$];
    int          e_idx  [$];
    logic [DW-1:0] e_line;
    logic [3:0] b;
    bit skip;
    for (int i = 0; i < NW; i++) begin
      b = rw ? be[4*i +: 4] : 4'hF;
      skip = 1'b0;
`ifdef L2_BUS_ADAPTER_SKIP_ZERO_BE_EN
      skip = rw && (b == 4'h0);
`endif
      if (!skip) begin
        e_addr.push_back(32'((64'(addr) * LINE_SIZE) + 4 * i));
        e_be.push_back(b);
        e_wd.push_back(data[32*i +: 32]);
        e_idx.push_back(i);
      end
      e_line[32*i +: 32] = rd_w[i];
    end

    check_eq("idle_ready", DW'(mem_req_ready_o), DW'(1));
    mem_req_valid_i  = 1'b1;
    mem_req_rw_i     = rw;
    mem_req_addr_i   = addr;
    mem_req_byteen_i = be;
    mem_req_data_i   = data;
    mem_req_tag_i    = tag;
    @(negedge clk_i);
    mem_req_valid_i  = 1'b0;
    mem_req_data_i   = DW'({$urandom, $urandom, $urandom, $urandom});

    for (int k = 0; k < e_addr.size(); k++) begin
      for (int s = 0; s <= gnt_dly; s++) begin
        check_eq("bus_req", DW'(bus_req_o), DW'(1));
        check_eq("bus_addr", DW'(bus_addr_o), DW'(e_addr[k]));
        check_eq("bus_we", DW'(bus_we_o), DW'(rw));
        check_eq("bus_be", DW'(bus_be_o), DW'(e_be[k]));
        check_eq("bus_wdata", DW'(bus_wdata_o), DW'(e_wd[k]));
        check_eq("busy_ready", DW'(mem_req_ready_o), DW'(0));
        if (s < gnt_dly) @(negedge clk_i);
      end
      bus_gnt_i = 1'b1;
      @(negedge clk_i);
      bus_gnt_i = 1'b0;
      check_eq("wait_req", DW'(bus_req_o), DW'(0));
      check_eq("wait_rsp_valid", DW'(mem_rsp_valid_o), DW'(0));
      if (abort_word == k) begin
        rst_ni = 1'b0;
        #1;
        check_eq("rst_bus_req", DW'(bus_req_o), DW'(0));
        check_eq("rst_ready", DW'(mem_req_ready_o), DW'(1));
        check_eq("rst_rsp_valid", DW'(mem_rsp_valid_o), DW'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        return;
      end
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rd_w[e_idx[k]];
      @(negedge clk_i);
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
    end

    if (!rw) begin
      for (int s = 0; s <= rsp_dly; s++) begin
        check_eq("rsp_valid", DW'(mem_rsp_valid_o), DW'(1));
        check_eq("rsp_data", mem_rsp_data_o, e_line);
        check_eq("rsp_tag", DW'(mem_rsp_tag_o), DW'(tag));
        check_eq("rsp_busy_ready", DW'(mem_req_ready_o), DW'(0));
        check_eq("rsp_bus_req", DW'(bus_req_o), DW'(0));
        if (s < rsp_dly) begin
          mem_req_valid_i = 1'b1;
          @(negedge clk_i);
        end
      end
      mem_req_valid_i = 1'b0;
      mem_rsp_ready_i = 1'b1;
      @(negedge clk_i);
      mem_rsp_ready_i = 1'b0;
    end
    check_eq("done_ready", DW'(mem_req_ready_o), DW'(1));
    check_eq("done_rsp_valid", DW'(mem_rsp_valid_o), DW'(0));
    check_eq("done_bus_req", DW'(bus_req_o), DW'(0));
  endtask

  initial begin
    logic [LINE_SIZE-1:0] be;
    logic [DW-1:0] data;
    rst_ni = 1'b0;
    mem_req_valid_i = 1'b0; mem_req_rw_i = 1'b0; mem_req_byteen_i = '0;
    mem_req_addr_i = '0; mem_req_data_i = '0; mem_req_tag_i = '0;
    mem_rsp_ready_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("reset_ready", DW'(mem_req_ready_o), DW'(1));
    check_eq("reset_bus_req", DW'(bus_req_o), DW'(0));
    check_eq("reset_we", DW'(bus_we_o), DW'(0));
    check_eq("reset_be", DW'(bus_be_o), DW'(0));
    check_eq("reset_addr", DW'(bus_addr_o), DW'(0));
    check_eq("reset_wdata", DW'(bus_wdata_o), DW'(0));
    check_eq("reset_rsp_valid", DW'(mem_rsp_valid_o), DW'(0));
    check_eq("reset_rsp_data", mem_rsp_data_o, DW'(0));
    check_eq("reset_rsp_tag", DW'(mem_rsp_tag_o), DW'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed read with the documented return words.
    rd_w[0] = 32'h11; rd_w[1] = 32'h22; rd_w[2] = 32'h33; rd_w[3] = 32'h44;
    run_line(1'b0, 28'h0000040, '0, '0, 8'h5A, 0, 0, -1);

    // Directed write with alternating empty words.
    data = {32'hD, 32'hC, 32'hB, 32'hA};
    run_line(1'b1, 28'h10, 16'hF0F0, data, 8'h01, 0, 0, -1);

    // Grant stalled for 5 cycles, response stalled for 3.
    for (int i = 0; i < NW; i++) rd_w[i] = $urandom;
    run_line(1'b0, 28'h0ABCDEF, '0, DW'({$urandom, $urandom, $urandom, $urandom}), 8'hC3, 5, 3, -1);
    run_line(1'b1, 28'h0123456, 16'h0FF1, DW'({$urandom, $urandom, $urandom, $urandom}), 8'h3C, 5, 0, -1);

    // Reset during WAIT of word 2, then a clean read from word 0.
    run_line(1'b0, 28'h0000777, '0, '0, 8'h77, 0, 0, 2);
    for (int i = 0; i < NW; i++) rd_w[i] = $urandom;
    run_line(1'b0, 28'h0000777, '0, '0, 8'h78, 0, 0, -1);

    // Spurious rvalid while idle.
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk_i);
      check_eq("spur_ready", DW'(mem_req_ready_o), DW'(1));
      check_eq("spur_rsp_valid", DW'(mem_rsp_valid_o), DW'(0));
      check_eq("spur_bus_req", DW'(bus_req_o), DW'(0));
    end
    bus_rvalid_i = 1'b0;

    // All-zero-enable write.
    run_line(1'b1, 28'h0000ABC, '0, DW'({$urandom, $urandom, $urandom, $urandom}), 8'h00, 0, 0, -1);

    // Randomized lines.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NW; i++) begin
        rd_w[i] = $urandom;
        be[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) be = '0;
      data = DW'({$urandom, $urandom, $urandom, $urandom});
      run_line(1'($urandom), AW'($urandom), be, data, TW'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
